// File: rtl/ram_scan_reader.sv
// RAM scan reader: steps through every word of a single-port RAM on a switch
// edge, holding each word on the display for a dwell period, and performs a
// single manual read whenever the manual address changes while idle.
module ram_scan_reader #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 2,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              CLOCK_50,
  input  logic              RESETN,
  input  logic              scan_sw,
  input  logic [ADDR_W-1:0] man_addr,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy,
  output logic              done
);

  // One counter serves both the read wait and the dwell, so it is sized for the larger
  localparam int CNT_W = $clog2(TICK_DIV + 8);
  localparam logic [CNT_W-1:0]  WAIT_LAST  = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DWELL,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q, sync_prev_q;
  logic              start_evt;
  logic              man_change;
  logic              scan_mode_q, scan_mode_d;
  logic [ADDR_W-1:0] last_man_q, last_man_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [ADDR_W-1:0] disp_addr_d;
  logic [DATA_W-1:0] disp_data_d;
  logic              disp_valid_d;
  logic              busy_d;

  assign start_evt  = sync2_q & ~sync_prev_q;
  assign man_change = (man_addr != last_man_q);

  // Bring the raw switch into the clock domain and keep one extra sample for edge detection
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      sync1_q     <= scan_sw;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
    end
  end

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, done pulse and next values for every datapath register
  always_comb begin
    state_d      = state_q;
    ram_addr_d   = ram_addr;
    disp_addr_d  = disp_addr;
    disp_data_d  = disp_data;
    disp_valid_d = disp_valid;
    busy_d       = busy;
    scan_mode_d  = scan_mode_q;
    last_man_d   = last_man_q;
    cnt_d        = cnt_q;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (man_change) begin
          last_man_d = man_addr;
        end
        if (start_evt) begin
          state_d     = ISSUE;
          ram_addr_d  = '0;
          scan_mode_d = 1'b1;
          busy_d      = 1'b1;
        end else if (man_change) begin
          state_d     = ISSUE;
          ram_addr_d  = man_addr;
          scan_mode_d = 1'b0;
        end
      end
      ISSUE: begin
        disp_valid_d = 1'b0;
        cnt_d        = '0;
        state_d      = WAIT;
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        disp_data_d  = ram_q;
        disp_addr_d  = ram_addr;
        disp_valid_d = 1'b1;
        cnt_d        = '0;
        state_d      = scan_mode_q ? DWELL : IDLE;
      end
      DWELL: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (ram_addr == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            ram_addr_d = ram_addr + ADDR_W'(1);
            state_d    = ISSUE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        done        = 1'b1;
        busy_d      = 1'b0;
        scan_mode_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      ram_addr    <= '0;
      disp_addr   <= '0;
      disp_data   <= '0;
      disp_valid  <= 1'b0;
      busy        <= 1'b0;
      scan_mode_q <= 1'b0;
      last_man_q  <= '0;
      cnt_q       <= '0;
    end else begin
      ram_addr    <= ram_addr_d;
      disp_addr   <= disp_addr_d;
      disp_data   <= disp_data_d;
      disp_valid  <= disp_valid_d;
      busy        <= busy_d;
      scan_mode_q <= scan_mode_d;
      last_man_q  <= last_man_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Testbench for ram_scan_reader: randomized manual reads and scans, with a
// scoreboard of expected captures, done pulses and busy window.
module tb_ram_scan_reader;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 8;
  localparam int READ_LAT = 2;
  localparam int TICK_DIV = 4;

  // Timing rules of the block, in clock cycles
  localparam int SYNC_DLY = 3;
  localparam int READ_DLY = READ_LAT + 2;
  localparam int PERIOD   = 2 + READ_LAT + TICK_DIV;
  localparam int NWORDS   = 1 << ADDR_W;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  logic              CLOCK_50 = 1'b0;
  logic              RESETN;
  logic              scan_sw;
  logic [ADDR_W-1:0] man_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [NWORDS];
  logic [DATA_W-1:0] rd_pipe [READ_LAT];

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  int   mdl_last = 0;
  logic prev_valid = 1'b0;
  exp_t sb [$];
  int   dq [$];

  ram_scan_reader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .READ_LAT(READ_LAT),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESETN(RESETN),
    .scan_sw(scan_sw),
    .man_addr(man_addr),
    .ram_addr(ram_addr),
    .ram_q(ram_q),
    .disp_addr(disp_addr),
    .disp_data(disp_data),
    .disp_valid(disp_valid),
    .busy(busy),
    .done(done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // RAM with a READ_LAT-deep read pipeline
  initial begin
    for (int i = 0; i < NWORDS; i++) mem[i] = DATA_W'(i * 3 + 1);
    for (int i = 0; i < READ_LAT; i++) rd_pipe[i] = '0;
  end

  always @(posedge CLOCK_50) begin
    rd_pipe[0] <= mem[ram_addr];
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign ram_q = rd_pipe[READ_LAT-1];

  function automatic int ramWord(input int a);
    return (a * 3 + 1) % 256;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic applyStimulus(input logic sw, input logic [ADDR_W-1:0] ma);
    scan_sw  = sw;
    man_addr = ma;
  endtask

  // A manual address change while idle yields one capture READ_DLY cycles after IDLE sees it
  task automatic doManual(input int a);
    exp_t e;
    applyStimulus(scan_sw, ADDR_W'(a));
    if (a != mdl_last) begin
      e.addr = a;
      e.data = ramWord(a);
      e.cyc  = cyc + 1 + READ_DLY;
      sb.push_back(e);
    end
    mdl_last = a;
  endtask

  // A switch rise starts a scan; words are expected every PERIOD cycles
  task automatic startScan(input int nWords, input bit full, output int k);
    exp_t e;
    applyStimulus(1'b1, man_addr);
    k = cyc;
    for (int i = 0; i < nWords; i++) begin
      e.addr = i;
      e.data = ramWord(i);
      e.cyc  = k + SYNC_DLY + READ_DLY + i * PERIOD;
      sb.push_back(e);
    end
    busy_lo = k + SYNC_DLY;
    if (full) begin
      busy_hi = k + SYNC_DLY + READ_DLY + (NWORDS - 1) * PERIOD + TICK_DIV;
      dq.push_back(busy_hi);
    end else begin
      busy_hi = 1 << 30;
    end
  endtask

  // Monitor: compares captures, done pulses and busy against the scoreboard
  always @(negedge CLOCK_50) begin : monitor
    exp_t e;
    if (RESETN !== 1'b1) begin
      prev_valid = 1'b0;
    end else begin
      if (disp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_capture: got addr %0d data %0d, expected none (cycle %0d)",
                   disp_addr, disp_data, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("capture_addr", int'(disp_addr), e.addr);
          checkOutput("capture_data", int'(disp_data), e.data);
          checkOutput("capture_cycle", cyc, e.cyc);
        end
      end
      prev_valid = disp_valid;
      if (done) begin
        if (dq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_done: got pulse, expected none (cycle %0d)", cyc);
        end else begin
          checkOutput("done_cycle", cyc, dq.pop_front());
        end
      end
      checkOutput("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int k;
    int k2;
    RESETN = 1'b0;
    applyStimulus(1'b0, '0);
    waitCycles(3);
    checkOutput("rst_ram_addr", int'(ram_addr), 0);
    checkOutput("rst_disp_addr", int'(disp_addr), 0);
    checkOutput("rst_disp_data", int'(disp_data), 0);
    checkOutput("rst_disp_valid", int'(disp_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    RESETN = 1'b1;
    waitCycles(10);

    $display("[TB] manual read 0 -> 5");
    doManual(5);
    waitCycles(12);

    $display("[TB] random manual reads");
    for (int i = 0; i < 10; i++) begin
      doManual(int'($urandom_range(0, NWORDS - 1)));
      waitCycles(int'($urandom_range(7, 12)));
    end

    $display("[TB] full scan with switch toggles and a man_addr change");
    startScan(NWORDS, 1'b1, k);
    for (int i = 0; i < 6; i++) begin
      waitCycles(int'($urandom_range(5, 20)));
      applyStimulus(~scan_sw, man_addr);
      if (i == 3) applyStimulus(scan_sw, ADDR_W'(9));
    end
    while (cyc < busy_hi + 1) waitCycles(1);
    checkOutput("ram_addr_after_scan", int'(ram_addr), NWORDS - 1);
    doManual(9);
    waitCycles(30);

    $display("[TB] restart scan and reset at address 12");
    applyStimulus(1'b0, man_addr);
    waitCycles(6);
    startScan(13, 1'b0, k2);
    waitCycles(20);
    applyStimulus(1'b0, '0);
    while (cyc < k2 + SYNC_DLY + READ_DLY + 12 * PERIOD + 2) waitCycles(1);
    checkOutput("ram_addr_mid_scan", int'(ram_addr), 12);
    busy_hi = cyc - 1;
    RESETN = 1'b0;
    #1;
    checkOutput("async_ram_addr", int'(ram_addr), 0);
    checkOutput("async_disp_addr", int'(disp_addr), 0);
    checkOutput("async_disp_data", int'(disp_data), 0);
    checkOutput("async_disp_valid", int'(disp_valid), 0);
    checkOutput("async_busy", int'(busy), 0);
    checkOutput("async_done", int'(done), 0);
    mdl_last = 0;
    waitCycles(3);
    RESETN = 1'b1;
    waitCycles(20);
    checkOutput("idle_disp_valid", int'(disp_valid), 0);

    $display("[TB] manual read after reset");
    doManual(int'($urandom_range(1, NWORDS - 1)));
    waitCycles(12);

    checkOutput("captures_left", sb.size(), 0);
    checkOutput("done_left", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_scan_reader.md
RAM_SCAN_READER -- requirements
Module: ram_scan_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter READ_LAT, default 2, CLOCK_50 cycles from ram_addr change to valid ram_q; legal range 1..7.
REQ-004 SHALL have parameter TICK_DIV, default 50_000_000, CLOCK_50 cycles each scanned word stays displayed; legal minimum 1.
REQ-005 SHALL have port CLOCK_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port RESETN, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port scan_sw, input, 1 bit: raw switch, asynchronous to CLOCK_50; a rising edge starts a full scan.
REQ-008 SHALL have port man_addr, input, ADDR_W bits: manual read address used when no scan is running.
REQ-009 SHALL have port ram_addr, output, ADDR_W bits: read address to the single-port RAM.
REQ-010 SHALL have port ram_q, input, DATA_W bits: RAM read data.
REQ-011 SHALL have port disp_addr, output, ADDR_W bits: address of the word in disp_data.
REQ-012 SHALL have port disp_data, output, DATA_W bits: last captured read data.
REQ-013 SHALL have port disp_valid, output, 1 bit: disp_data/disp_addr hold a completed read.
REQ-014 SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at scan completion.

Function
REQ-016 scan_sw SHALL pass through a 2-flop synchronizer; a start event SHALL be synced=1 while the previous synced sample=0.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, CAPTURE, DWELL, DONE.
REQ-018 IDLE: start event -> ISSUE with scan address 0 and busy=1; otherwise, if man_addr differs from the stored last-manual address -> store it and go to ISSUE in manual mode.
REQ-019 ISSUE (1 cycle): drive ram_addr with the current address, clear disp_valid, then go to WAIT.
REQ-020 WAIT SHALL last exactly READ_LAT cycles with ram_addr held stable, then go to CAPTURE.
REQ-021 CAPTURE (1 cycle): disp_data<=ram_q, disp_addr<=ram_addr, disp_valid<=1; manual mode -> IDLE, scan mode -> DWELL.
REQ-022 DWELL SHALL last exactly TICK_DIV cycles; then address 2^ADDR_W-1 -> DONE, otherwise address+1 -> ISSUE.
REQ-023 DONE (1 cycle): done=1, busy<=0, then go to IDLE; the scan address SHALL NOT wrap to 0.
REQ-024 Per-word scan period SHALL be 2+READ_LAT+TICK_DIV cycles; manual read latency SHALL be READ_LAT+2 cycles from IDLE detecting the change to disp_data update.
REQ-025 During a scan, start events and man_addr changes SHALL be ignored; a scan_sw fall SHALL NOT abort the scan.
REQ-026 A man_addr change made during a scan SHALL trigger one manual read on return to IDLE.
REQ-027 If a start event and a man_addr change occur in the same IDLE cycle, the start SHALL win and the last-manual address SHALL still be updated.
REQ-028 ram_addr SHALL be a registered output and change only on entry to ISSUE.

Reset
REQ-029 RESETN=0 SHALL immediately force IDLE, ram_addr=0, disp_addr=0, disp_data=0, disp_valid=0, busy=0, done=0, last-manual address=0, and clear the synchronizer and edge flops.
REQ-030 Reset mid-scan SHALL abandon the scan; no done pulse SHALL be issued.
REQ-031 After reset release, the block SHALL perform no RAM read until a start event or a man_addr change from 0.

Verification (READ_LAT=2, TICK_DIV=4, RAM model preloaded mem[i]=i*3+1)
REQ-032 Reset, then man_addr 0->5 -> disp_data=0x10, disp_addr=5, disp_valid=1 exactly 4 cycles after IDLE sees the change.
REQ-033 scan_sw 0->1 -> disp_data steps 0x01, 0x04, ..., 0x5E every 8 cycles; busy=1 throughout; single done pulse after address 31; ram_addr stays 31.
REQ-034 During a scan, toggle scan_sw and change man_addr to 9 -> scan is unaffected; after done, one manual read shows disp_data=0x1C.
REQ-035 Assert RESETN=0 at scanned address 12 -> all outputs return to 0 asynchronously; no done pulse; IDLE after release.
REQ-036 scan_sw held high after done -> no new scan; a fresh 0->1 edge restarts the scan at address 0.
